// File: rtl/msx_cart_bus_bridge_pkg.sv
// Shared definitions for the MSX cartridge bus bridge: FSM encodings, counter widths
// and the value driven on td when a read is aborted.
package msx_cart_bus_bridge_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned WAIT_CNT_W = 8;
  localparam int unsigned TO_CNT_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [DATA_W-1:0] TD_FLOAT = 8'hFF;

  // Saturating increment for the wait-state counter
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == '1) ? v : v + WAIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/msx_cart_bus_bridge_sync_edge.sv
// Synchroniser for one active-low async strobe, with a falling-edge pulse on the
// synchronised level. Flops reset to the inactive (high) level.
module msx_cart_bus_bridge_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_chain;
  logic              r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '1;
      r_prev  <= 1'b1;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
      r_prev  <= r_chain[STAGES-1];
    end
  end

  assign o_sync   = r_chain[STAGES-1];
  assign o_fall_c = r_prev & ~r_chain[STAGES-1];

endmodule

// File: rtl/msx_cart_bus_bridge.sv
// Bridges asynchronous MSX cartridge strobes onto a single-clock req/ack slave bus,
// with /WAIT insertion, td output-enable control and timeout recovery.
module msx_cart_bus_bridge
  import msx_cart_bus_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W      = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned WAIT_EN     = 1,
  parameter int unsigned MIN_WAIT    = 4,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              n_ce,
  input  logic              n_trd,
  input  logic              n_twr,
  input  logic [ADDR_W-1:0] ta,
  input  logic [7:0]        td_in,
  output logic [7:0]        td_out,
  output logic              td_oe,
  output logic              twait,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              bus_wr,
  output logic [ADDR_W-1:0] bus_address,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_rdata_en,
  output logic              timeout_err
);

  logic w_ce_s, w_rd_s, w_wr_s;
  logic w_ce_fall_unused, w_rd_fall, w_wr_fall;

  msx_cart_bus_bridge_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ce (
    .clk(clk), .reset(reset), .i_async(n_ce),  .o_sync(w_ce_s), .o_fall_c(w_ce_fall_unused)
  );
  msx_cart_bus_bridge_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
    .clk(clk), .reset(reset), .i_async(n_trd), .o_sync(w_rd_s), .o_fall_c(w_rd_fall)
  );
  msx_cart_bus_bridge_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
    .clk(clk), .reset(reset), .i_async(n_twr), .o_sync(w_wr_s), .o_fall_c(w_wr_fall)
  );

  logic [1:0]            r_state, w_state_nxt;
  logic                  r_bus_req, w_bus_req_nxt;
  logic                  r_bus_wr, w_bus_wr_nxt;
  logic [ADDR_W-1:0]     r_bus_address, w_bus_address_nxt;
  logic [DATA_W-1:0]     r_bus_wdata, w_bus_wdata_nxt;
  logic [DATA_W-1:0]     r_td_out, w_td_out_nxt;
  logic                  r_td_oe, w_td_oe_nxt;
  logic                  r_twait, w_twait_nxt;
  logic                  r_timeout_err, w_timeout_err_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [TO_CNT_W-1:0]   r_to_cnt, w_to_cnt_nxt;
  logic                  r_released, w_released_nxt;

  // A start with both strobes low is not a legal cycle and is dropped
  logic w_start_rd, w_start_wr, w_strobe_rel, w_rel_any;
  logic w_wait_done, w_to_hit, w_ack_req, w_rd_data;

  assign w_start_rd   = ~w_ce_s & w_rd_fall & w_wr_s;
  assign w_start_wr   = ~w_ce_s & w_wr_fall & w_rd_s;
  assign w_strobe_rel = w_ce_s | (r_bus_wr ? w_wr_s : w_rd_s);
  assign w_rel_any    = r_released | w_strobe_rel;
  assign w_wait_done  = r_wait_cnt >= WAIT_CNT_W'(MIN_WAIT);
  assign w_to_hit     = r_to_cnt >= TO_CNT_W'(TIMEOUT - 1);
  assign w_ack_req    = (r_state == ST_REQ) & bus_ack;
  assign w_rd_data    = ~r_bus_wr & bus_rdata_en & ((r_state == ST_DATA) | w_ack_req);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_bus_req_nxt     = r_bus_req;
    w_bus_wr_nxt      = r_bus_wr;
    w_bus_address_nxt = r_bus_address;
    w_bus_wdata_nxt   = r_bus_wdata;
    w_td_out_nxt      = r_td_out;
    w_td_oe_nxt       = r_td_oe;
    w_twait_nxt       = r_twait;
    w_timeout_err_nxt = 1'b0;
    w_wait_cnt_nxt    = sat_inc(r_wait_cnt);
    w_to_cnt_nxt      = r_to_cnt;
    w_released_nxt    = r_released;

    case (r_state)
      ST_IDLE: begin
        w_wait_cnt_nxt = r_wait_cnt;
        if (w_start_rd | w_start_wr) begin
          w_state_nxt       = ST_REQ;
          w_bus_req_nxt     = 1'b1;
          w_bus_wr_nxt      = w_start_wr;
          w_bus_address_nxt = ta;
          w_bus_wdata_nxt   = td_in;
          w_twait_nxt       = (WAIT_EN != 0);
          w_wait_cnt_nxt    = '0;
          w_to_cnt_nxt      = '0;
          w_released_nxt    = 1'b0;
        end
      end

      ST_REQ, ST_DATA: begin
        w_to_cnt_nxt   = r_to_cnt + TO_CNT_W'(1);
        w_released_nxt = w_rel_any;
        if (w_ack_req) begin
          w_bus_req_nxt = 1'b0;
          w_state_nxt   = r_bus_wr ? ST_DONE : ST_DATA;
        end
        if (w_rd_data) begin
          w_state_nxt = ST_DONE;
          if (!w_rel_any) begin
            w_td_out_nxt = bus_rdata;
            w_td_oe_nxt  = 1'b1;
          end
        end else if (w_to_hit && !w_ack_req) begin
          w_state_nxt       = ST_DONE;
          w_bus_req_nxt     = 1'b0;
          w_timeout_err_nxt = 1'b1;
          if (!r_bus_wr && !w_rel_any) begin
            w_td_out_nxt = TD_FLOAT;
            w_td_oe_nxt  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        if (w_wait_done) w_twait_nxt = 1'b0;
        if (w_strobe_rel) begin
          w_td_oe_nxt = 1'b0;
          w_twait_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bus_req     <= 1'b0;
      r_bus_wr      <= 1'b0;
      r_bus_address <= '0;
      r_bus_wdata   <= '0;
      r_td_out      <= '0;
      r_td_oe       <= 1'b0;
      r_twait       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
      r_to_cnt      <= '0;
      r_released    <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_bus_req     <= w_bus_req_nxt;
      r_bus_wr      <= w_bus_wr_nxt;
      r_bus_address <= w_bus_address_nxt;
      r_bus_wdata   <= w_bus_wdata_nxt;
      r_td_out      <= w_td_out_nxt;
      r_td_oe       <= w_td_oe_nxt;
      r_twait       <= w_twait_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_to_cnt      <= w_to_cnt_nxt;
      r_released    <= w_released_nxt;
    end
  end

  assign td_out      = r_td_out;
  assign td_oe       = r_td_oe;
  assign twait       = r_twait;
  assign bus_req     = r_bus_req;
  assign bus_wr      = r_bus_wr;
  assign bus_address = r_bus_address;
  assign bus_wdata   = r_bus_wdata;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_msx_cart_bus_bridge.sv
// Scoreboard bench for msx_cart_bus_bridge: stimulus queues expected bus requests,
// pad read data and timeout ages; a negedge monitor pops and compares them.
module tb_msx_cart_bus_bridge;

  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned MIN_WAIT = 4;
  localparam int unsigned TIMEOUT  = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              n_ce = 1'b1, n_trd = 1'b1, n_twr = 1'b1;
  logic [ADDR_W-1:0] ta = '0;
  logic [7:0]        td_in = 8'h00;
  logic [7:0]        td_out;
  logic              td_oe, twait, bus_req, bus_wr, timeout_err;
  logic [ADDR_W-1:0] bus_address;
  logic [7:0]        bus_wdata;
  logic              bus_ack = 1'b0, bus_rdata_en = 1'b0;
  logic [7:0]        bus_rdata = 8'h00;

  logic              n_ce2 = 1'b1, n_trd2 = 1'b1, n_twr2 = 1'b1;
  logic [ADDR_W-1:0] ta2 = '0;
  logic [7:0]        td_in2 = 8'h00;
  logic [7:0]        td_out2;
  logic              td_oe2, twait2, bus_req2, bus_wr2, timeout_err2;
  logic [ADDR_W-1:0] bus_address2;
  logic [7:0]        bus_wdata2;
  logic              bus_ack2 = 1'b0, bus_rdata_en2 = 1'b0;
  logic [7:0]        bus_rdata2 = 8'h00;

  msx_cart_bus_bridge #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(2), .WAIT_EN(1), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
  ) u_dut (
    .clk(clk), .reset(reset), .n_ce(n_ce), .n_trd(n_trd), .n_twr(n_twr), .ta(ta),
    .td_in(td_in), .td_out(td_out), .td_oe(td_oe), .twait(twait), .bus_req(bus_req),
    .bus_ack(bus_ack), .bus_wr(bus_wr), .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en), .timeout_err(timeout_err)
  );

  msx_cart_bus_bridge #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(2), .WAIT_EN(0), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
  ) u_dut_nw (
    .clk(clk), .reset(reset), .n_ce(n_ce2), .n_trd(n_trd2), .n_twr(n_twr2), .ta(ta2),
    .td_in(td_in2), .td_out(td_out2), .td_oe(td_oe2), .twait(twait2), .bus_req(bus_req2),
    .bus_ack(bus_ack2), .bus_wr(bus_wr2), .bus_address(bus_address2), .bus_wdata(bus_wdata2),
    .bus_rdata(bus_rdata2), .bus_rdata_en(bus_rdata_en2), .timeout_err(timeout_err2)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit              wr;
    bit [ADDR_W-1:0] addr;
    bit [7:0]        data;
  } req_t;

  req_t     q_req[$];
  bit [7:0] q_pad[$];
  int       q_to[$];

  task automatic chk(input string nm, input bit ok, input longint act, input longint req);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // Slave model: ack (with rdata_en) sl_dly cycles after bus_req rises
  bit       sl_en = 1'b1;
  int       sl_dly = 3;
  bit [7:0] sl_rdata = 8'h00;
  int       sl_cnt = 0;

  always @(negedge clk) begin
    if (reset || !bus_req) begin
      sl_cnt       = 0;
      bus_ack      = 1'b0;
      bus_rdata_en = 1'b0;
    end else begin
      sl_cnt++;
      if (sl_en && sl_cnt == sl_dly) begin
        bus_ack      = 1'b1;
        bus_rdata_en = 1'b1;
        bus_rdata    = sl_rdata;
      end else begin
        bus_ack      = 1'b0;
        bus_rdata_en = 1'b0;
      end
    end
  end

  // Monitor for the main instance
  bit   prev_req = 1'b0, prev_oe = 1'b0, prev_tw = 1'b0;
  int   age = 0, tw_cnt = 0;
  req_t e;

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0; prev_oe = 1'b0; prev_tw = 1'b0; tw_cnt = 0;
    end else begin
      if (bus_req && !prev_req) begin
        age = 0;
        if (q_req.size() == 0) chk("unexpected_bus_req", 1'b0, 1, 0);
        else begin
          e = q_req.pop_front();
          chk("bus_wr", bus_wr == e.wr, bus_wr, e.wr);
          chk("bus_address", bus_address == e.addr, bus_address, e.addr);
          if (e.wr) chk("bus_wdata", bus_wdata == e.data, bus_wdata, e.data);
        end
      end else begin
        age++;
      end
      if (td_oe && !prev_oe) begin
        if (q_pad.size() == 0) chk("unexpected_td_oe", 1'b0, 1, 0);
        else begin
          bit [7:0] d;
          d = q_pad.pop_front();
          chk("td_out", td_out == d, td_out, d);
        end
      end
      if (timeout_err) begin
        if (q_to.size() == 0) chk("unexpected_timeout", 1'b0, 1, 0);
        else begin
          int a;
          a = q_to.pop_front();
          chk("timeout_age", age == a, age, a);
        end
      end
      if (twait) tw_cnt++;
      else begin
        if (prev_tw) chk("twait_min_width", tw_cnt >= int'(MIN_WAIT), tw_cnt, MIN_WAIT);
        tw_cnt = 0;
      end
      prev_req = bus_req; prev_oe = td_oe; prev_tw = twait;
    end
  end

  bit seen_oe2 = 1'b0, seen_tw2 = 1'b0, seen_to2 = 1'b0;
  always @(negedge clk) begin
    if (td_oe2)       seen_oe2 = 1'b1;
    if (twait2)       seen_tw2 = 1'b1;
    if (timeout_err2) seen_to2 = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start(input bit wr, input bit [ADDR_W-1:0] a, input bit [7:0] d);
    ta = a; td_in = d; n_ce = 1'b0;
    if (wr) n_twr = 1'b0; else n_trd = 1'b0;
  endtask

  task automatic release_all();
    n_ce = 1'b1; n_trd = 1'b1; n_twr = 1'b1;
  endtask

  task automatic push_req(input bit wr, input bit [ADDR_W-1:0] a, input bit [7:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.data = d;
    q_req.push_back(r);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cyc(3);
    chk("rst_ctrl", {bus_req, twait, td_oe, bus_wr, timeout_err} == 5'b0,
        {bus_req, twait, td_oe, bus_wr, timeout_err}, 0);
    chk("rst_td_out", td_out == 8'h00, td_out, 0);
    reset = 1'b0;
    cyc(5);

    // Write, slave acks after 3 cycles
    sl_en = 1'b1; sl_dly = 3;
    push_req(1'b1, 2'd1, 8'hA5);
    start(1'b1, 2'd1, 8'hA5);
    cyc(40);
    chk("wr_done_req_low", bus_req == 1'b0, bus_req, 0);
    release_all();
    cyc(10);

    // Read, slave returns 8'h3C after 10 cycles
    sl_dly = 10; sl_rdata = 8'h3C;
    push_req(1'b0, 2'd2, 8'h00);
    q_pad.push_back(8'h3C);
    start(1'b0, 2'd2, 8'h00);
    cyc(40);
    chk("rd_twait_low", twait == 1'b0, twait, 0);
    chk("rd_td_oe_high", td_oe == 1'b1, td_oe, 1);
    n_trd = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rd_oe_hold", td_oe == 1'b1, td_oe, 1);
    @(posedge clk);
    @(negedge clk);
    chk("rd_oe_release", td_oe == 1'b0, td_oe, 0);
    release_all();
    cyc(10);

    // Read with no slave response
    sl_en = 1'b0;
    push_req(1'b0, 2'd3, 8'h00);
    q_to.push_back(255);
    q_pad.push_back(8'hFF);
    start(1'b0, 2'd3, 8'h00);
    cyc(280);
    chk("to_twait_low", twait == 1'b0, twait, 0);
    chk("to_req_low", bus_req == 1'b0, bus_req, 0);
    release_all();
    cyc(10);

    // No-wait instance: strobe released before the slave acks
    ta2 = 2'd3; td_in2 = 8'h11; n_ce2 = 1'b0; n_trd2 = 1'b0;
    cyc(2);
    n_ce2 = 1'b1; n_trd2 = 1'b1;
    for (int i = 0; i < 20 && !bus_req2; i++) @(negedge clk);
    chk("nw_req_seen", bus_req2 == 1'b1, bus_req2, 1);
    chk("nw_bus_wr", bus_wr2 == 1'b0, bus_wr2, 0);
    chk("nw_bus_address", bus_address2 == 2'd3, bus_address2, 3);
    chk("nw_bus_wdata", bus_wdata2 == 8'h11, bus_wdata2, 8'h11);
    repeat (8) @(posedge clk);
    #2;
    chk("nw_req_held", bus_req2 == 1'b1, bus_req2, 1);
    bus_ack2 = 1'b1; bus_rdata_en2 = 1'b1; bus_rdata2 = 8'h77;
    cyc(1);
    bus_ack2 = 1'b0; bus_rdata_en2 = 1'b0;
    chk("nw_req_dropped", bus_req2 == 1'b0, bus_req2, 0);
    cyc(10);
    chk("nw_td_oe_never", seen_oe2 == 1'b0, seen_oe2, 0);
    chk("nw_twait_never", seen_tw2 == 1'b0, seen_tw2, 0);
    chk("nw_timeout_never", seen_to2 == 1'b0, seen_to2, 0);
    chk("nw_td_out", td_out2 == 8'h00, td_out2, 0);

    // Reset while a read is pending, then a normal write
    sl_en = 1'b0;
    push_req(1'b0, 2'd1, 8'h00);
    start(1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 20 && !bus_req; i++) @(negedge clk);
    chk("mid_req_seen", bus_req == 1'b1, bus_req, 1);
    cyc(3);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", {bus_req, twait, td_oe, bus_wr, timeout_err} == 5'b0,
        {bus_req, twait, td_oe, bus_wr, timeout_err}, 0);
    chk("mid_rst_addr", bus_address == '0, bus_address, 0);
    release_all();
    cyc(3);
    reset = 1'b0;
    cyc(5);
    sl_en = 1'b1; sl_dly = 2;
    push_req(1'b1, 2'd0, 8'h5A);
    start(1'b1, 2'd0, 8'h5A);
    cyc(20);
    chk("post_rst_req_low", bus_req == 1'b0, bus_req, 0);
    release_all();
    cyc(10);

    // Illegal strobe combinations must not start a transaction
    n_ce = 1'b0; n_trd = 1'b0; n_twr = 1'b0;
    cyc(20);
    chk("both_strobes_no_req", bus_req == 1'b0, bus_req, 0);
    release_all();
    cyc(5);
    n_twr = 1'b0;
    cyc(20);
    chk("ce_high_no_req", bus_req == 1'b0, bus_req, 0);
    release_all();
    cyc(10);

    chk("q_req_drained", q_req.size() == 0, q_req.size(), 0);
    chk("q_pad_drained", q_pad.size() == 0, q_pad.size(), 0);
    chk("q_to_drained", q_to.size() == 0, q_to.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
